// File: rtl/br_resolve_if.sv
// EX-stage branch resolution bundle: resolved branch info in, BTB/fetch control
// and statistics out.
interface br_resolve_if #(
  parameter int CNT_W = 32
);
  logic             IsBr_EX;
  logic             BTB_hit_EX;
  logic             br;
  logic [31:0]      PCE;
  logic [31:0]      br_target;
  logic [31:0]      pred_target_EX;
  logic             bubbleE;
  logic             flushE;
  logic             BufferWrite;
  logic             BufferDelete;
  logic             mispredict;
  logic [31:0]      redirect_pc;
  logic [CNT_W-1:0] br_count;
  logic [CNT_W-1:0] mispred_count;

  modport master (
    output IsBr_EX, BTB_hit_EX, br, PCE, br_target, pred_target_EX, bubbleE, flushE,
    input  BufferWrite, BufferDelete, mispredict, redirect_pc, br_count, mispred_count
  );

  modport slave (
    input  IsBr_EX, BTB_hit_EX, br, PCE, br_target, pred_target_EX, bubbleE, flushE,
    output BufferWrite, BufferDelete, mispredict, redirect_pc, br_count, mispred_count
  );
endinterface

// File: rtl/br_resolve_unit.sv
// Resolves conditional branches in EX: detects mispredictions, drives BTB
// maintenance, trains a 2-bit BHT and keeps branch/misprediction statistics.
module br_resolve_unit #(
  parameter int IDX_W = 6,
  parameter int CNT_W = 32
) (
  input logic        clk,
  input logic        rst_n,
  br_resolve_if.slave bus
);
  localparam int ENTRIES = 1 << IDX_W;

  logic [1:0]       bht_q [ENTRIES];
  logic             done_q, done_d;
  logic [CNT_W-1:0] br_cnt_q, br_cnt_d;
  logic [CNT_W-1:0] mp_cnt_q, mp_cnt_d;
  logic [IDX_W-1:0] idx;
  logic [1:0]       ctr, ctr_d;
  logic             bv, tgt_miss, misp;

  function automatic logic [1:0] sat_step(input logic [1:0] c, input logic up);
    if (up) return (c == 2'b11) ? c : c + 2'd1;
    else    return (c == 2'b00) ? c : c - 2'd1;
  endfunction

  assign idx      = bus.PCE[IDX_W+1:2];
  assign ctr      = bht_q[idx];
  // rst_n gates bv so every output is quiet while reset is held
  assign bv       = rst_n & bus.IsBr_EX & ~bus.flushE & ~done_q;
  assign tgt_miss = bus.pred_target_EX != bus.br_target;
  assign misp     = bv & ((bus.BTB_hit_EX ^ bus.br) | (bus.BTB_hit_EX & bus.br & tgt_miss));

  assign bus.mispredict    = misp;
  assign bus.redirect_pc   = misp ? (bus.br ? bus.br_target : bus.PCE + 32'd4) : 32'd0;
  assign bus.BufferWrite   = bv & bus.br & (~bus.BTB_hit_EX | tgt_miss);
  assign bus.BufferDelete  = bv & bus.BTB_hit_EX & ~bus.br & ~ctr[1];
  assign bus.br_count      = br_cnt_q;
  assign bus.mispred_count = mp_cnt_q;

  always_comb begin
    // done remembers that a stalled branch already updated state
    done_d   = bus.bubbleE ? (done_q | bv) : 1'b0;
    br_cnt_d = br_cnt_q + CNT_W'(bv);
    mp_cnt_d = mp_cnt_q + CNT_W'(misp);
    ctr_d    = sat_step(ctr, bus.br);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_q   <= 1'b0;
      br_cnt_q <= '0;
      mp_cnt_q <= '0;
    end else begin
      done_q   <= done_d;
      br_cnt_q <= br_cnt_d;
      mp_cnt_q <= mp_cnt_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) bht_q[i] <= 2'b01;
    end else if (bv) begin
      bht_q[idx] <= ctr_d;
    end
  end
endmodule

// File: tb/tb_br_resolve_unit.sv
// Bench for br_resolve_unit: directed vector table, hand-built stall/wrap/reset
// sequences and randomized traffic against a behavioural model.
module tb_br_resolve_unit;
  localparam int IDX_W = 6;
  localparam int CNT_W = 4;
  localparam int NENT  = 1 << IDX_W;
  localparam int CMOD  = 1 << CNT_W;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  br_resolve_if #(.CNT_W(CNT_W)) bus ();
  br_resolve_unit #(.IDX_W(IDX_W), .CNT_W(CNT_W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int tests = 0;
  int failed = 0;

  // behavioural model state
  int bht_m [NENT];
  int brc_m, mpc_m;
  bit stalled_done_m;

  typedef struct {
    bit isbr, hit, br, flush, bubble;
    logic [31:0] pce, tgt, pred;
    bit e_mis, e_bw, e_bd;
    logic [31:0] e_rd;
    int e_bht, e_brc, e_mpc;
  } vec_t;
  vec_t tbl [10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic int idx_of(input logic [31:0] pce);
    return int'((pce >> 2) % NENT);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NENT; i++) bht_m[i] = 1;
    brc_m = 0; mpc_m = 0; stalled_done_m = 0;
  endtask

  function automatic bit model_valid();
    return bus.IsBr_EX && !bus.flushE && !stalled_done_m;
  endfunction

  // Prediction was "taken iff BTB hit, to the BTB target"; any disagreement is a mispredict.
  task automatic model_eval(output bit mis, output bit bw, output bit bd, output logic [31:0] rd);
    bit v, wrong_tgt;
    v = model_valid();
    wrong_tgt = bus.pred_target_EX != bus.br_target;
    mis = v && ((bus.BTB_hit_EX != bus.br) || (bus.BTB_hit_EX && bus.br && wrong_tgt));
    bw  = v && bus.br && (!bus.BTB_hit_EX || wrong_tgt);
    bd  = v && bus.BTB_hit_EX && !bus.br && (bht_m[idx_of(bus.PCE)] <= 1);
    rd  = !mis ? 32'd0 : (bus.br ? bus.br_target : bus.PCE + 32'd4);
  endtask

  task automatic model_update();
    bit mis, bw, bd, v;
    logic [31:0] rd;
    int k;
    model_eval(mis, bw, bd, rd);
    v = model_valid();
    k = idx_of(bus.PCE);
    if (v) begin
      if (bus.br) bht_m[k] = (bht_m[k] == 3) ? 3 : bht_m[k] + 1;
      else        bht_m[k] = (bht_m[k] == 0) ? 0 : bht_m[k] - 1;
      brc_m = (brc_m + 1) % CMOD;
      if (mis) mpc_m = (mpc_m + 1) % CMOD;
    end
    if (!bus.bubbleE) stalled_done_m = 0;
    else if (v) stalled_done_m = 1;
  endtask

  task automatic drive(input bit isbr, hit, br, flush, bubble,
                       input logic [31:0] pce, tgt, pred);
    bus.IsBr_EX = isbr; bus.BTB_hit_EX = hit; bus.br = br;
    bus.flushE = flush; bus.bubbleE = bubble;
    bus.PCE = pce; bus.br_target = tgt; bus.pred_target_EX = pred;
  endtask

  // One clock against the model: compare at negedge, advance model at posedge.
  task automatic run_cycle(input string tag);
    bit mis, bw, bd;
    logic [31:0] rd;
    model_eval(mis, bw, bd, rd);
    @(negedge clk);
    chk({tag, ".mispredict"}, 32'(bus.mispredict), 32'(mis));
    chk({tag, ".bw"}, 32'(bus.BufferWrite), 32'(bw));
    chk({tag, ".bd"}, 32'(bus.BufferDelete), 32'(bd));
    chk({tag, ".redirect"}, bus.redirect_pc, rd);
    chk({tag, ".bw_bd_excl"}, 32'(bus.BufferWrite & bus.BufferDelete), 32'd0);
    chk({tag, ".brc"}, 32'(bus.br_count), 32'(brc_m));
    chk({tag, ".mpc"}, 32'(bus.mispred_count), 32'(mpc_m));
    chk({tag, ".bht"}, 32'(dut.bht_q[idx_of(bus.PCE)]), 32'(bht_m[idx_of(bus.PCE)]));
    @(posedge clk);
    model_update();
    #1;
  endtask

  initial begin
    logic [31:0] pcs [5];
    int brc0, guard;

    // REQ-031..035 style vectors; expectations derived by hand from reset state
    //          isbr hit br fl bub pce       tgt        pred       mis bw bd redir      bht brc mpc
    tbl[0] = '{1, 0, 1, 0, 0, 32'h100, 32'h80,  32'h0,   1, 1, 0, 32'h80,  2, 1, 1};
    tbl[1] = '{1, 1, 1, 0, 0, 32'h200, 32'h200, 32'h200, 0, 0, 0, 32'h0,   3, 2, 1};
    tbl[2] = '{1, 1, 1, 0, 0, 32'h200, 32'h200, 32'h200, 0, 0, 0, 32'h0,   3, 3, 1};
    tbl[3] = '{1, 1, 0, 0, 0, 32'h40,  32'h90,  32'h90,  1, 0, 1, 32'h44,  0, 4, 2};
    tbl[4] = '{1, 1, 0, 0, 0, 32'h100, 32'h90,  32'h90,  1, 0, 0, 32'h104, 2, 5, 3};
    tbl[5] = '{1, 1, 1, 0, 0, 32'h300, 32'h304, 32'h300, 1, 1, 0, 32'h304, 3, 6, 4};
    tbl[6] = '{1, 1, 1, 1, 0, 32'h300, 32'h304, 32'h300, 0, 0, 0, 32'h0,   3, 6, 4};
    tbl[7] = '{0, 1, 1, 0, 0, 32'h300, 32'h304, 32'h300, 0, 0, 0, 32'h0,   3, 6, 4};
    tbl[8] = '{1, 0, 0, 0, 0, 32'h44,  32'h90,  32'h0,   0, 0, 0, 32'h0,   0, 7, 4};
    tbl[9] = '{1, 0, 1, 1, 1, 32'h44,  32'h90,  32'h0,   0, 0, 0, 32'h0,   0, 7, 4};

    // reset held: a live branch on the inputs must not show through
    drive(1, 0, 1, 0, 0, 32'h100, 32'h80, 32'h0);
    model_reset();
    #12;
    chk("rst.mispredict", 32'(bus.mispredict), 32'd0);
    chk("rst.bw", 32'(bus.BufferWrite), 32'd0);
    chk("rst.redirect", bus.redirect_pc, 32'd0);
    chk("rst.brc", 32'(bus.br_count), 32'd0);
    chk("rst.mpc", 32'(bus.mispred_count), 32'd0);
    chk("rst.bht0", 32'(dut.bht_q[0]), 32'd1);
    chk("rst.bht63", 32'(dut.bht_q[63]), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      drive(tbl[i].isbr, tbl[i].hit, tbl[i].br, tbl[i].flush, tbl[i].bubble,
            tbl[i].pce, tbl[i].tgt, tbl[i].pred);
      @(negedge clk);
      chk($sformatf("vec%0d.mispredict", i), 32'(bus.mispredict), 32'(tbl[i].e_mis));
      chk($sformatf("vec%0d.bw", i), 32'(bus.BufferWrite), 32'(tbl[i].e_bw));
      chk($sformatf("vec%0d.bd", i), 32'(bus.BufferDelete), 32'(tbl[i].e_bd));
      chk($sformatf("vec%0d.redirect", i), bus.redirect_pc, tbl[i].e_rd);
      @(posedge clk);
      model_update();
      #1;
      chk($sformatf("vec%0d.bht", i), 32'(dut.bht_q[idx_of(tbl[i].pce)]), 32'(tbl[i].e_bht));
      chk($sformatf("vec%0d.brc", i), 32'(bus.br_count), 32'(tbl[i].e_brc));
      chk($sformatf("vec%0d.mpc", i), 32'(bus.mispred_count), 32'(tbl[i].e_mpc));
    end

    // branch stalled for three cycles, then released
    brc0 = brc_m;
    drive(1, 0, 1, 0, 1, 32'h80, 32'h500, 32'h0);
    run_cycle("stall1");
    run_cycle("stall2");
    run_cycle("stall3");
    bus.bubbleE = 1'b0;
    run_cycle("stall_rel");
    chk("stall.brc_once", 32'(bus.br_count), 32'((brc0 + 1) % CMOD));
    drive(0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0);
    run_cycle("idle");

    // drive mispredictions until the counter wraps
    guard = 0;
    drive(1, 0, 1, 0, 0, 32'h500, 32'h600, 32'h0);
    while (mpc_m != CMOD - 1 && guard < 2 * CMOD) begin
      run_cycle("wrap_fill");
      guard++;
    end
    chk("wrap.reached_max", 32'(bus.mispred_count), 32'(CMOD - 1));
    run_cycle("wrap");
    chk("wrap.mpc_zero", 32'(bus.mispred_count), 32'd0);

    // asynchronous reset mid-cycle with a stalled branch held in EX
    drive(1, 0, 1, 0, 1, 32'h100, 32'h80, 32'h0);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst.brc", 32'(bus.br_count), 32'd0);
    chk("arst.mispredict", 32'(bus.mispredict), 32'd0);
    chk("arst.bht", 32'(dut.bht_q[idx_of(32'h500)]), 32'd1);
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_cycle("post_rst_stall1");
    run_cycle("post_rst_stall2");
    bus.bubbleE = 1'b0;
    run_cycle("post_rst_rel");

    // randomized traffic
    pcs[0] = 32'h100; pcs[1] = 32'h104; pcs[2] = 32'h148; pcs[3] = 32'hFFFF_FFFC; pcs[4] = 32'h10C;
    for (int n = 0; n < 500; n++) begin
      drive($urandom_range(0, 3) != 0, 1'($urandom), 1'($urandom),
            $urandom_range(0, 9) == 0, $urandom_range(0, 3) == 0,
            pcs[$urandom_range(0, 4)],
            ($urandom_range(0, 1) != 0) ? 32'h200 : 32'h204,
            ($urandom_range(0, 1) != 0) ? 32'h200 : 32'h204);
      run_cycle("rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule

// File: doc/br_resolve_unit.md
BR_RESOLVE_UNIT -- requirements
Module: br_resolve_unit

Interface
REQ-001 SHALL have parameter IDX_W, default 6, meaning BHT index width (2^IDX_W entries, indexed by PCE[IDX_W+1:2]).
REQ-002 SHALL have parameter CNT_W, default 32, meaning width of each statistics counter.
REQ-003 SHALL have one clock and an asynchronous active-low reset, named clk and rst_n.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 IsBr_EX  input  1  instruction in EX is a conditional branch.
REQ-007 BTB_hit_EX  input  1  fetch-time BTB hit recorded for the EX instruction.
REQ-008 br  input  1  resolved branch outcome in EX (1 = taken).
REQ-009 PCE  input  32  PC of the EX instruction.
REQ-010 br_target  input  32  resolved taken target.
REQ-011 pred_target_EX  input  32  target predicted at fetch; meaningful only when BTB_hit_EX = 1.
REQ-012 bubbleE, flushE  input  1 each  EX stage stall and EX stage flush.
REQ-013 BufferWrite  output  1  allocate or overwrite BTB entry {PCE, br_target}.
REQ-014 BufferDelete  output  1  invalidate the BTB entry for PCE.
REQ-015 mispredict  output  1  request flush of IF/ID and redirect fetch.
REQ-016 redirect_pc  output  32  fetch address used when mispredict = 1.
REQ-017 br_count, mispred_count  output  CNT_W each  resolved branches and mispredictions since reset.

Function
REQ-018 Branch is valid (bv) SHALL be asserted iff IsBr_EX & ~flushE & ~done, where done is an internal register.
REQ-019 done SHALL set at a rising edge when bv & bubbleE, and SHALL clear at any edge with ~bubbleE, so a stalled branch updates state exactly once.
REQ-020 mispredict SHALL be combinational: bv & ((BTB_hit_EX & ~br) | (~BTB_hit_EX & br) | (BTB_hit_EX & br & pred_target_EX != br_target)).
REQ-021 redirect_pc SHALL be br_target when br = 1, else PCE + 4 (modulo 2^32); it SHALL be 0 when mispredict = 0.
REQ-022 The BHT SHALL hold one 2-bit saturating counter per entry (00 strong NT, 01 weak NT, 10 weak T, 11 strong T); on bv it SHALL increment (saturating at 11) if br = 1, else decrement (saturating at 00), written at the next rising edge.
REQ-023 BufferWrite SHALL be combinational: bv & br & (~BTB_hit_EX | pred_target_EX != br_target).
REQ-024 BufferDelete SHALL be combinational: bv & BTB_hit_EX & ~br & (current counter <= 01).
REQ-025 BufferWrite and BufferDelete SHALL never be asserted in the same cycle.
REQ-026 On bv, br_count SHALL increment by 1 and mispred_count SHALL increment by 1 when mispredict = 1; both SHALL wrap from 2^CNT_W-1 to 0.
REQ-027 With IsBr_EX = 0 or flushE = 1, all combinational outputs SHALL be 0 and no state SHALL change, except that done follows REQ-019.
REQ-028 flushE and bubbleE both high SHALL be treated as a flush: no update, and done set/clear SHALL follow REQ-019 on bubbleE only.

Reset
REQ-029 While rst_n = 0: every BHT entry SHALL be 01, done = 0, br_count = 0, mispred_count = 0, and all outputs SHALL be 0, regardless of clk.
REQ-030 Reset deassertion mid-stall SHALL leave done = 0, so a branch still held in EX updates once after reset.

Verification
REQ-031 After reset: PCE = 0x100, IsBr_EX = 1, hit = 0, br = 1, br_target = 0x80 -> mispredict = 1, redirect_pc = 0x80, BufferWrite = 1; next cycle BHT[0x100] = 10, br_count = 1, mispred_count = 1.
REQ-032 Hit = 1, br = 1, pred_target_EX = br_target = 0x200 -> mispredict = 0, BufferWrite = 0, BufferDelete = 0; counter saturates at 11 after a second repeat.
REQ-033 Counter at 01, hit = 1, br = 0, PCE = 0x40 -> mispredict = 1, redirect_pc = 0x44, BufferDelete = 1; counter becomes 00. From 11 with the same stimulus -> BufferDelete = 0, counter becomes 10.
REQ-034 Branch held with bubbleE = 1 for 3 cycles -> br_count +1 only, outputs high only in the first cycle.
REQ-035 Hit = 1, br = 1, pred_target_EX = 0x300, br_target = 0x304 -> mispredict = 1, BufferWrite = 1, redirect_pc = 0x304; flushE = 1 with the same stimulus -> all outputs 0 and no state change.
REQ-036 Preload mispred_count = 2^CNT_W-1, then apply a mispredicting branch -> mispred_count wraps to 0; asserting rst_n = 0 mid-cycle clears all state immediately.
